// File: rtl/itag_array_coherent_pkg.sv
// Shared types and defaults for the coherent I-cache tag array.
// Holds no logic and adds no latency; flow control lives in the users of the package.
package itag_array_coherent_pkg;

    localparam int DEFAULT_WAYS  = 2;
    localparam int DEFAULT_LINES = 64;

    typedef enum logic [1:0] {
        FLUSH,
        IDLE,
        SNOOP_RD,
        SNOOP_WR
    } port_b_state_t;

    // The 32-bit byte address splits into {tag, line, word, byte}.
    function automatic int tag_width(input int sub_line_addr_w, input int line_addr_w);
        return 32 - 2 - sub_line_addr_w - line_addr_w;
    endfunction

    function automatic int entry_width(input int tag_w);
        return tag_w + 1;
    endfunction

endpackage

// File: rtl/itag_array_coherent_tag_bank.sv
// One way of tag storage: port A is read-only, port B is read/write, both with a registered read.
// Read latency is 1 cycle on either port; there is no backpressure, and port A returns the old entry on a same-cycle write.
module itag_array_coherent_tag_bank #(
    parameter int WIDTH  = 23,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [WIDTH-1:0]  a_dout,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_din,
    output logic [WIDTH-1:0]  b_dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_dout <= mem[a_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            if (b_we) begin
                mem[b_addr] <= b_din;
            end else begin
                b_dout <= mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/itag_array_coherent.sv
// N-way I-cache tag array with fill, snoop-invalidate and flush on a shared port B.
// Lookup hit is 1 cycle after stage1_adv; snoops hold snoop_valid until snoop_ack, and fills must not be issued while flush_busy is high.
module itag_array_coherent
    import itag_array_coherent_pkg::*;
#(
    parameter int WAYS            = DEFAULT_WAYS,
    parameter int LINES           = DEFAULT_LINES,
    parameter int LINE_ADDR_W     = $clog2(LINES),
    parameter int SUB_LINE_ADDR_W = 2,
    parameter int TAG_W           = tag_width(SUB_LINE_ADDR_W, LINE_ADDR_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     stage1_addr,
    input  logic            stage1_adv,
    input  logic [31:0]     stage2_addr,
    input  logic            update,
    input  logic [WAYS-1:0] update_way,
    input  logic            snoop_valid,
    input  logic [31:0]     snoop_addr,
    output logic            snoop_ack,
    input  logic            flush_req,
    output logic            flush_busy,
    output logic            tag_hit,
    output logic [WAYS-1:0] tag_hit_way
);

    localparam int ENTRY_W  = entry_width(TAG_W);
    localparam int LINE_LSB = SUB_LINE_ADDR_W + 2;
    localparam int TAG_LSB  = LINE_LSB + LINE_ADDR_W;
    localparam logic [LINE_ADDR_W-1:0] LAST_LINE = LINE_ADDR_W'(LINES - 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [LINE_ADDR_W-1:0] s1_line, s2_line, snoop_line;
    entry_t                 s2_entry, snoop_entry;

    assign s1_line     = stage1_addr[LINE_LSB +: LINE_ADDR_W];
    assign s2_line     = stage2_addr[LINE_LSB +: LINE_ADDR_W];
    assign snoop_line  = snoop_addr[LINE_LSB +: LINE_ADDR_W];
    assign s2_entry    = '{valid: 1'b1, tag: stage2_addr[TAG_LSB +: TAG_W]};
    assign snoop_entry = '{valid: 1'b1, tag: snoop_addr[TAG_LSB +: TAG_W]};

    logic unused_addr_bits;
    assign unused_addr_bits = ^{stage1_addr[LINE_LSB-1:0], stage1_addr[31:TAG_LSB],
                                stage2_addr[LINE_LSB-1:0], snoop_addr[LINE_LSB-1:0]};

    port_b_state_t          state, state_nxt;
    logic [LINE_ADDR_W-1:0] flush_cnt, flush_cnt_nxt;
    logic                   hit_allowed;

    logic                   pb_en;
    logic [WAYS-1:0]        pb_we;
    logic [LINE_ADDR_W-1:0] pb_addr;
    entry_t                 pb_din;
    logic                   snoop_clear;

    entry_t                 rd_a [WAYS];
    entry_t                 rd_b [WAYS];
    logic [WAYS-1:0]        snoop_match;
    logic [WAYS-1:0]        raw_hit;
    logic [WAYS-1:0]        suppress;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        itag_array_coherent_tag_bank #(
            .WIDTH (ENTRY_W),
            .DEPTH (LINES),
            .ADDR_W(LINE_ADDR_W)
        ) u_bank (
            .clk   (clk),
            .a_en  (stage1_adv),
            .a_addr(s1_line),
            .a_dout(rd_a[w]),
            .b_en  (pb_en),
            .b_we  (pb_we[w]),
            .b_addr(pb_addr),
            .b_din (pb_din),
            .b_dout(rd_b[w])
        );

        assign snoop_match[w] = (rd_b[w] == snoop_entry);
        assign raw_hit[w]     = hit_allowed && (rd_a[w] == s2_entry);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FLUSH;
            flush_cnt   <= '0;
            hit_allowed <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_cnt   <= flush_cnt_nxt;
            hit_allowed <= stage1_adv;
        end
    end

    // Port B arbitration: flush beats fill, fill beats snoop.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        pb_en         = 1'b0;
        pb_we         = '0;
        pb_addr       = s2_line;
        pb_din        = '0;
        snoop_clear   = 1'b0;
        snoop_ack     = 1'b0;
        flush_busy    = 1'b0;

        unique case (state)
            FLUSH: begin
                flush_busy    = 1'b1;
                pb_en         = 1'b1;
                pb_we         = '1;
                pb_addr       = flush_cnt;
                flush_cnt_nxt = flush_cnt + 1'b1;
                if (flush_cnt == LAST_LINE) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = '0;
                end else if (update) begin
                    pb_en  = 1'b1;
                    pb_we  = update_way;
                    pb_din = s2_entry;
                end else if (snoop_valid) begin
                    state_nxt = SNOOP_RD;
                end
            end
            SNOOP_RD: begin
                if (flush_req) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = '0;
                end else if (update) begin
                    pb_en  = 1'b1;
                    pb_we  = update_way;
                    pb_din = s2_entry;
                end else begin
                    pb_en     = 1'b1;
                    pb_addr   = snoop_line;
                    state_nxt = SNOOP_WR;
                end
            end
            SNOOP_WR: begin
                if (flush_req) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = '0;
                end else if (update) begin
                    // The fill may install the snooped tag, so the line is read again.
                    pb_en     = 1'b1;
                    pb_we     = update_way;
                    pb_din    = s2_entry;
                    state_nxt = SNOOP_RD;
                end else begin
                    pb_en       = |snoop_match;
                    pb_we       = snoop_match;
                    pb_addr     = snoop_line;
                    snoop_clear = 1'b1;
                    snoop_ack   = !rst;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt     = FLUSH;
                flush_cnt_nxt = '0;
            end
        endcase
    end

    // A lookup registered before the invalidate still holds the old entry.
    always_comb begin
        suppress = '0;
        if (state == FLUSH) begin
            suppress = '1;
        end else if (snoop_clear && (snoop_line == s2_line)) begin
            suppress = snoop_match;
        end
    end

    assign tag_hit_way = raw_hit & ~suppress;
    assign tag_hit     = |tag_hit_way;

endmodule

// File: tb/tb_itag_array_coherent.sv
// Self-checking bench for itag_array_coherent: table-driven lookups plus hand-written snoop/flush sequences.
module tb_itag_array_coherent;

    localparam int WAYS  = 2;
    localparam int LINES = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     stage1_addr;
    logic            stage1_adv;
    logic [31:0]     stage2_addr;
    logic            update;
    logic [WAYS-1:0] update_way;
    logic            snoop_valid;
    logic [31:0]     snoop_addr;
    logic            snoop_ack;
    logic            flush_req;
    logic            flush_busy;
    logic            tag_hit;
    logic [WAYS-1:0] tag_hit_way;

    int checks        = 0;
    int failures      = 0;
    int ack_busy_viol = 0;

    logic [WAYS-1:0] exp_q [$];

    typedef struct {
        logic [31:0]     addr;
        logic [WAYS-1:0] exp_way;
    } vec_t;

    vec_t vecs [7];

    itag_array_coherent #(
        .WAYS (WAYS),
        .LINES(LINES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stage1_addr(stage1_addr),
        .stage1_adv (stage1_adv),
        .stage2_addr(stage2_addr),
        .update     (update),
        .update_way (update_way),
        .snoop_valid(snoop_valid),
        .snoop_addr (snoop_addr),
        .snoop_ack  (snoop_ack),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .tag_hit    (tag_hit),
        .tag_hit_way(tag_hit_way)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (snoop_ack && flush_busy) ack_busy_viol++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string name, input logic [31:0] addr, input logic [WAYS-1:0] exp);
        logic [WAYS-1:0] e;
        tick();
        stage1_adv  = 1'b1;
        stage1_addr = addr;
        exp_q.push_back(exp);
        tick();
        stage1_adv  = 1'b0;
        stage2_addr = addr;
        @(negedge clk);
        e = exp_q.pop_front();
        check({name, "_way"}, 32'(tag_hit_way), 32'(e));
        check({name, "_hit"}, 32'(tag_hit), 32'(|e));
    endtask

    task automatic fill(input logic [31:0] addr, input logic [WAYS-1:0] way);
        tick();
        stage2_addr = addr;
        update      = 1'b1;
        update_way  = way;
        tick();
        update      = 1'b0;
        update_way  = '0;
    endtask

    // lat counts cycles with snoop_valid high, inclusive of the ack cycle; 0 means no ack.
    task automatic snoop(input logic [31:0] addr, output int lat);
        lat = 0;
        tick();
        snoop_valid = 1'b1;
        snoop_addr  = addr;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (snoop_ack) begin
                lat = n;
                break;
            end
            tick();
        end
        tick();
        snoop_valid = 1'b0;
    endtask

    initial begin
        int n;
        int lat;
        int busy_cnt;
        int ack_at;

        vecs[0] = '{32'h0000_1000, 2'b10};
        vecs[1] = '{32'h0000_100C, 2'b10};
        vecs[2] = '{32'h0000_2000, 2'b01};
        vecs[3] = '{32'h0000_3000, 2'b00};
        vecs[4] = '{32'h0000_0410, 2'b10};
        vecs[5] = '{32'h0000_0400, 2'b00};
        vecs[6] = '{32'h0000_1010, 2'b00};

        rst         = 1'b1;
        stage1_addr = '0;
        stage1_adv  = 1'b0;
        stage2_addr = '0;
        update      = 1'b0;
        update_way  = '0;
        snoop_valid = 1'b0;
        snoop_addr  = '0;
        flush_req   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_snoop_ack", 32'(snoop_ack), 0);
        check("rst_tag_hit", 32'(tag_hit), 0);
        check("rst_tag_hit_way", 32'(tag_hit_way), 0);
        check("rst_flush_busy", 32'(flush_busy), 1);

        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!flush_busy) break;
            n++;
            tick();
        end
        check("reset_flush_len", n, LINES);

        lookup("pre_fill", 32'h0000_1000, 2'b00);
        fill(32'h0000_1000, 2'b10);
        lookup("fill_hit", 32'h0000_1000, 2'b10);
        fill(32'h0000_2000, 2'b01);
        fill(32'h0000_0410, 2'b10);

        for (int i = 0; i < 7; i++) begin
            lookup($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_way);
        end

        snoop(32'h0000_1004, lat);
        check("snoop_lat", lat, 3);
        lookup("after_snoop", 32'h0000_1000, 2'b00);
        snoop(32'h0000_3000, lat);
        check("snoop_other_lat", lat, 3);
        lookup("other_tag_kept", 32'h0000_2000, 2'b01);
        lookup("other_line_kept", 32'h0000_0410, 2'b10);

        // Fill of the snooped tag lands during SNOOP_WR.
        tick();
        snoop_valid = 1'b1;
        snoop_addr  = 32'h0000_5000;
        tick();
        tick();
        update      = 1'b1;
        update_way  = 2'b10;
        stage2_addr = 32'h0000_5000;
        @(negedge clk);
        check("collide_no_ack", 32'(snoop_ack), 0);
        tick();
        update      = 1'b0;
        update_way  = '0;
        @(negedge clk);
        check("collide_reread_no_ack", 32'(snoop_ack), 0);
        tick();
        @(negedge clk);
        check("collide_ack", 32'(snoop_ack), 1);
        tick();
        snoop_valid = 1'b0;
        lookup("collide_invalidated", 32'h0000_5000, 2'b00);

        // Registered lookup lands in the same cycle as the invalidate of its way.
        tick();
        snoop_valid = 1'b1;
        snoop_addr  = 32'h0000_2004;
        tick();
        stage1_adv  = 1'b1;
        stage1_addr = 32'h0000_2000;
        tick();
        stage1_adv  = 1'b0;
        stage2_addr = 32'h0000_2000;
        @(negedge clk);
        check("stale_hit", 32'(tag_hit), 0);
        check("stale_hit_way", 32'(tag_hit_way), 0);
        check("stale_ack", 32'(snoop_ack), 1);
        tick();
        snoop_valid = 1'b0;
        lookup("stale_after", 32'h0000_2000, 2'b00);

        // flush_req while the snoop is in SNOOP_RD.
        tick();
        snoop_valid = 1'b1;
        snoop_addr  = 32'h0000_0410;
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        busy_cnt = 0;
        ack_at   = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (snoop_ack) begin
                ack_at = i;
                break;
            end
            if (flush_busy) busy_cnt++;
            tick();
        end
        tick();
        snoop_valid = 1'b0;
        check("flush_mid_snoop_len", busy_cnt, LINES);
        check("flush_mid_snoop_ack_cycle", ack_at, LINES + 2);
        lookup("post_flush_0410", 32'h0000_0410, 2'b00);
        lookup("post_flush_1000", 32'h0000_1000, 2'b00);
        lookup("post_flush_2000", 32'h0000_2000, 2'b00);
        lookup("post_flush_5000", 32'h0000_5000, 2'b00);

        check("ack_with_busy", ack_busy_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/itag_array_coherent.md
# itag_array_coherent

Parametrised instruction-cache tag array for the dual-core fetch path, with N ways of {valid, tag} entries. Each core's fetch unit reads on port A and sees registered hit results in stage 2. Port B is shared by three maintenance sources: miss fills, snoop invalidations from the other core's store stream, and a full-array flush (FENCE.I or post-reset). This block replaces the fill-only tag array, which had no valid-clear path and relied on RAM initialisation.

## Interface
Parameters:
- WAYS, 2: number of ways, 1..8.
- LINES, 64: sets per way, power of two ≥ 2.
- LINE_ADDR_W, $clog2(LINES): set-index width.
- SUB_LINE_ADDR_W, 2: word-in-line index width.
- TAG_W, 32-2-SUB_LINE_ADDR_W-LINE_ADDR_W: tag width.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous and active-high.
- stage1_addr  in  32  lookup address.
- stage1_adv  in  1  port-A read enable; results are valid next cycle.
- stage2_addr  in  32  address compared against the registered tags; also the fill address.
- update  in  1  fill-write strobe.
- update_way  in  WAYS  one-hot victim way.
- snoop_valid  in  1  invalidate request; held until snoop_ack.
- snoop_addr  in  32  store address from the other core.
- snoop_ack  out  1  one-cycle pulse when the invalidate completes.
- flush_req  in  1  single-cycle pulse requesting invalidate-all.
- flush_busy  out  1  high during flush.
- tag_hit  out  1  OR of tag_hit_way.
- tag_hit_way  out  WAYS  per-way hit.

## Operation
- Line index is addr[SUB_LINE_ADDR_W+2 +: LINE_ADDR_W]. Tag is addr[SUB_LINE_ADDR_W+LINE_ADDR_W+2 +: TAG_W].
- A way hits when all of these hold:
  - hit_allowed is set (registered stage1_adv);
  - the stored entry equals {1, tag(stage2_addr)};
  - no suppression is active this cycle.
- Port-B FSM states are FLUSH, IDLE, SNOOP_RD and SNOOP_WR. Priority on port B is FLUSH > fill > snoop.
- FLUSH:
  - Writes {0,0} to every way at flush_cnt, then increments flush_cnt.
  - Leaves to IDLE after writing line LINES-1.
  - flush_busy=1 throughout; tag_hit_way is forced to 0.
  - update is ignored during FLUSH. The fetch unit must not fill while busy.
- IDLE:
  - update writes {1, tag(stage2_addr)} to the update_way ways at line(stage2_addr).
  - flush_req enters FLUSH with flush_cnt=0.
  - Otherwise, snoop_valid moves to SNOOP_RD.
- SNOOP_RD: performs a port-B read of line(snoop_addr), all ways. If update is high, the fill wins and the read retries next cycle.
- SNOOP_WR:
  - Computes match[w] = stored entry equals {1, tag(snoop_addr)}.
  - Writes {0,0} to the matching ways. Zero matches means no write.
  - Pulses snoop_ack and returns to IDLE.
  - If update is high, the fill wins, no ack is issued, and the FSM returns to SNOOP_RD. The re-read covers a fill that installed the snooped tag.
- flush_req in any snoop state aborts the snoop (no ack; the requester keeps snoop_valid high) and enters FLUSH. A snoop is re-served after the flush and will find no match.
- Stale-hit suppression: in a SNOOP_WR write cycle, clear tag_hit_way[w] for matching ways w when line(snoop_addr)==line(stage2_addr).
- An update to a way and line being read on port A in the same cycle returns the old entry (read-first).

## Timing
- Reset values: the FSM enters FLUSH with flush_cnt=0, so flush_busy=1 in the first cycle after rst. Also at reset, hit_allowed=0, snoop_ack=0, tag_hit=0 and tag_hit_way=0.
- rst asserted mid-flush or mid-snoop restarts FLUSH from line 0. Any pending snoop is not acked.
- A flush (reset or request) lasts exactly LINES cycles. flush_busy falls on the cycle after line LINES-1 is written.
- Lookup latency: 1 cycle from stage1_adv to tag_hit_way.
- Snoop: snoop_ack arrives 3 cycles after snoop_valid rises, measured from IDLE with no fill conflicts: IDLE → SNOOP_RD → SNOOP_WR, with the ack in SNOOP_WR. Each colliding fill adds 1 or 2 cycles.
- snoop_ack is never asserted in the same cycle as flush_busy.

## Structure
- The {valid, tag} entry type and the width helper functions go in taiga_types. Default WAYS and LINES go in taiga_config.
- Sub-module: the existing dual-port tag_bank, one instance per way, width TAG_W+1, depth LINES, read-first on port A.
- Port B addressing is muxed on FSM state: flush_cnt, line(snoop_addr) or line(stage2_addr).

## Test plan
- Reset then lookup: deassert rst and count flush_busy high for exactly 64 cycles (LINES=64). Then look up 0x0000_1000 → tag_hit=0.
- Fill/hit: fill update_way=2'b10 at 0x0000_1000. Then stage1_adv with the same address → tag_hit_way=2'b10 one cycle later.
- Snoop invalidate: snoop_addr=0x0000_1004 (same line) → snoop_ack 3 cycles later. The next lookup of 0x0000_1000 misses. A snoop to a different tag leaves the hit intact.
- Snoop/fill collision: assert update during SNOOP_WR with the fill installing the snooped tag → the fill occurs, the FSM re-reads, and the entry is invalidated before snoop_ack.
- Stale-hit suppression: the SNOOP_WR clear of the way holding stage2's line coincides with the registered lookup → tag_hit=0 that cycle.
- Flush mid-snoop: flush_req in SNOOP_RD → no ack during the flush. After LINES cycles the snoop is re-served, acks, and all lookups miss.
